// File: rtl/pw_trigger_seq_pkg.sv
// Shared types and constants for the multi-pulse trigger sequencer.
package pw_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } trig_state_e;

  localparam int unsigned MISSED_CNT_WIDTH = 8;

  function automatic logic is_busy(input trig_state_e s);
    return (s == DELAY) || (s == PULSE);
  endfunction

endpackage

// File: rtl/pw_trigger_seq_if.sv
// Control/status bundle of pw_trigger_seq; O_missed_count exists only with
// TRIGGER_MISSED_COUNT_EN defined.
interface pw_trigger_seq_if #(
  parameter int unsigned pNUM_TRIGGERS        = 4,
  parameter int unsigned pTRIGGER_DELAY_WIDTH = 20,
  parameter int unsigned pTRIGGER_WIDTH_WIDTH = 17,
  parameter int unsigned pIDX_WIDTH           = (pNUM_TRIGGERS > 1) ? $clog2(pNUM_TRIGGERS) : 1
);
  import pw_trigger_pkg::*;

  logic                                             I_arm;
  logic                                             I_abort;
  logic                                             I_match;
  logic [pIDX_WIDTH:0]                              I_num_triggers;
  logic [pNUM_TRIGGERS*pTRIGGER_DELAY_WIDTH-1:0]    I_trigger_delay;
  logic [pNUM_TRIGGERS*pTRIGGER_WIDTH_WIDTH-1:0]    I_trigger_width;
  logic                                             O_trigger;
  logic                                             O_trigger_pulse;
  logic [pIDX_WIDTH-1:0]                            O_trigger_index;
  logic                                             O_armed;
  logic                                             O_busy;
  logic                                             O_done_pulse;
`ifdef TRIGGER_MISSED_COUNT_EN
  logic [MISSED_CNT_WIDTH-1:0]                      O_missed_count;

  modport master (
    output I_arm, I_abort, I_match, I_num_triggers, I_trigger_delay, I_trigger_width,
    input  O_trigger, O_trigger_pulse, O_trigger_index, O_armed, O_busy, O_done_pulse,
           O_missed_count
  );
  modport slave (
    input  I_arm, I_abort, I_match, I_num_triggers, I_trigger_delay, I_trigger_width,
    output O_trigger, O_trigger_pulse, O_trigger_index, O_armed, O_busy, O_done_pulse,
           O_missed_count
  );
`else
  modport master (
    output I_arm, I_abort, I_match, I_num_triggers, I_trigger_delay, I_trigger_width,
    input  O_trigger, O_trigger_pulse, O_trigger_index, O_armed, O_busy, O_done_pulse
  );
  modport slave (
    input  I_arm, I_abort, I_match, I_num_triggers, I_trigger_delay, I_trigger_width,
    output O_trigger, O_trigger_pulse, O_trigger_index, O_armed, O_busy, O_done_pulse
  );
`endif

endinterface

// File: rtl/pw_trigger_seq_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
module pw_sat_counter
  import pw_trigger_pkg::*;
#(
  parameter int unsigned pWIDTH = MISSED_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [pWIDTH-1:0] count_o
);

  logic [pWIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + pWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: after one match, emits up to pNUM_TRIGGERS
// delayed pulses. TRIGGER_MISSED_COUNT_EN adds a saturating missed-match counter.
module pw_trigger_seq
  import pw_trigger_pkg::*;
#(
  parameter int unsigned pNUM_TRIGGERS        = 4,
  parameter int unsigned pTRIGGER_DELAY_WIDTH = 20,
  parameter int unsigned pTRIGGER_WIDTH_WIDTH = 17,
  parameter int unsigned pIDX_WIDTH           = (pNUM_TRIGGERS > 1) ? $clog2(pNUM_TRIGGERS) : 1
) (
  input logic             trigger_clk,
  input logic             reset_n,
  pw_trigger_seq_if.slave bus
);

  localparam int unsigned DW = pTRIGGER_DELAY_WIDTH;
  localparam int unsigned WW = pTRIGGER_WIDTH_WIDTH;
  localparam int unsigned CW = pIDX_WIDTH + 1;

  trig_state_e                   state_q, state_d;
  logic [pIDX_WIDTH-1:0]         idx_q, idx_d;
  logic [pNUM_TRIGGERS*DW-1:0]   delay_cfg_q, delay_cfg_d;
  logic [pNUM_TRIGGERS*WW-1:0]   width_cfg_q, width_cfg_d;
  logic [CW-1:0]                 count_q, count_d, count_in;
  logic [DW-1:0]                 dcnt_q, dcnt_d, cur_delay, delay_eff;
  logic [WW-1:0]                 wcnt_q, wcnt_d, cur_width, width_eff;
  logic                          trig_q, trig_d, pulse_q, pulse_d, done_q, done_d;
  logic                          arm_accept, busy, last_pulse;

  // Requested count clamped into 1..pNUM_TRIGGERS before it is snapshotted.
  always_comb begin
    count_in = bus.I_num_triggers;
    if (bus.I_num_triggers == '0) begin
      count_in = CW'(1);
    end else if (bus.I_num_triggers > CW'(pNUM_TRIGGERS)) begin
      count_in = CW'(pNUM_TRIGGERS);
    end
  end

  // Only pulses after the first ever see the DELAY state with a zero field,
  // so forcing the minimum to 1 here keeps D0 = 0 handled by ARMED.
  assign cur_delay  = delay_cfg_q[idx_q*DW +: DW];
  assign cur_width  = width_cfg_q[idx_q*WW +: WW];
  assign delay_eff  = (cur_delay == '0) ? DW'(1) : cur_delay;
  assign width_eff  = (cur_width == '0) ? WW'(1) : cur_width;
  assign last_pulse = (CW'(idx_q) + CW'(1)) >= count_q;
  assign busy       = is_busy(state_q);
  assign arm_accept = (state_q == IDLE) && bus.I_arm && !bus.I_abort;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    delay_cfg_d = delay_cfg_q;
    width_cfg_d = width_cfg_q;
    count_d     = count_q;
    dcnt_d      = dcnt_q;
    wcnt_d      = wcnt_q;
    done_d      = 1'b0;

    if (bus.I_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_accept) begin
            state_d     = ARMED;
            idx_d       = '0;
            delay_cfg_d = bus.I_trigger_delay;
            width_cfg_d = bus.I_trigger_width;
            count_d     = count_in;
          end
        end
        ARMED: begin
          if (bus.I_match) begin
            idx_d   = '0;
            dcnt_d  = '0;
            wcnt_d  = '0;
            state_d = (delay_cfg_q[DW-1:0] == '0) ? PULSE : DELAY;
          end
        end
        DELAY: begin
          if (dcnt_q == delay_eff - DW'(1)) begin
            state_d = PULSE;
            wcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        PULSE: begin
          if (wcnt_q == width_eff - WW'(1)) begin
            if (last_pulse) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DELAY;
              idx_d   = idx_q + pIDX_WIDTH'(1);
              dcnt_d  = '0;
            end
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      endcase
    end

    // Consecutive pulses are always separated by DELAY, so entering PULSE
    // marks exactly the first high cycle.
    trig_d  = (state_d == PULSE);
    pulse_d = (state_d == PULSE) && (state_q != PULSE);
  end

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      delay_cfg_q <= '0;
      width_cfg_q <= '0;
      count_q     <= '0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      trig_q      <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      delay_cfg_q <= delay_cfg_d;
      width_cfg_q <= width_cfg_d;
      count_q     <= count_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      trig_q      <= trig_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

  assign bus.O_trigger       = trig_q;
  assign bus.O_trigger_pulse = pulse_q;
  assign bus.O_trigger_index = idx_q;
  assign bus.O_armed         = (state_q == ARMED);
  assign bus.O_busy          = busy;
  assign bus.O_done_pulse    = done_q;

`ifdef TRIGGER_MISSED_COUNT_EN
  pw_sat_counter #(
    .pWIDTH(MISSED_CNT_WIDTH)
  ) u_missed_cnt (
    .clk    (trigger_clk),
    .rst_n  (reset_n),
    .clr_i  (arm_accept),
    .inc_i  (bus.I_match && busy),
    .count_o(bus.O_missed_count)
  );
`endif

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Bench for pw_trigger_seq: pulse-schedule reference model plus directed and random stimulus.
module tb_pw_trigger_seq;
  import pw_trigger_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 20;
  localparam int unsigned WW = 17;
  localparam int unsigned IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pw_trigger_seq_if #(
    .pNUM_TRIGGERS(N), .pTRIGGER_DELAY_WIDTH(DW),
    .pTRIGGER_WIDTH_WIDTH(WW), .pIDX_WIDTH(IW)
  ) bus ();

  pw_trigger_seq #(
    .pNUM_TRIGGERS(N), .pTRIGGER_DELAY_WIDTH(DW),
    .pTRIGGER_WIDTH_WIDTH(WW), .pIDX_WIDTH(IW)
  ) dut (
    .trigger_clk(clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a snapshot of the config and, once matched, the absolute
  // cycle window [ps[i], pe[i]] of every pulse in the train.
  bit m_armed = 1'b0;
  bit m_seq   = 1'b0;
  bit busy_c;
  int m_n, m_cnt, m_last, s;
  int held_idx = 0;
  int missed   = 0;
  int scount   = 1;
  int ps[N];
  int pe[N];
  int sd[N];
  int sw[N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_idx(input int t);
    int k;
    k = 0;
    if (!m_seq) return held_idx;
    for (int i = 0; i < m_cnt; i++) if (pe[i] < t) k++;
    if (k > m_cnt - 1) k = m_cnt - 1;
    return k;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_armed  = 1'b0;
      m_seq    = 1'b0;
      held_idx = 0;
      missed   = 0;
    end else begin
      busy_c = m_seq && (cyc > m_n) && (cyc <= m_last);
      if (bus.I_match && busy_c && missed < 255) missed++;
      if (bus.I_abort) begin
        if (m_seq) held_idx = exp_idx(cyc);
        m_seq   = 1'b0;
        m_armed = 1'b0;
      end else if (!m_armed && !busy_c && bus.I_arm) begin
        for (int i = 0; i < N; i++) begin
          sd[i] = int'(bus.I_trigger_delay[i*DW +: DW]);
          sw[i] = int'(bus.I_trigger_width[i*WW +: WW]);
        end
        scount = int'(bus.I_num_triggers);
        if (scount == 0) scount = 1;
        if (scount > N)  scount = N;
        m_armed  = 1'b1;
        m_seq    = 1'b0;
        held_idx = 0;
        missed   = 0;
      end else if (m_armed && bus.I_match) begin
        m_armed = 1'b0;
        m_seq   = 1'b1;
        m_n     = cyc;
        m_cnt   = scount;
        s       = cyc + 1 + sd[0];
        for (int i = 0; i < scount; i++) begin
          if (i > 0) s = pe[i-1] + 1 + ((sd[i] == 0) ? 1 : sd[i]);
          ps[i] = s;
          pe[i] = s + ((sw[i] == 0) ? 1 : sw[i]) - 1;
        end
        m_last = pe[scount-1];
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    bit et, ep;
    @(negedge clk);
    if (rst_n && cyc > 0) begin
      et = 1'b0;
      ep = 1'b0;
      if (m_seq) begin
        for (int i = 0; i < m_cnt; i++) begin
          if (cyc >= ps[i] && cyc <= pe[i]) et = 1'b1;
          if (cyc == ps[i]) ep = 1'b1;
        end
      end
      chk("trigger", int'(bus.O_trigger), int'(et));
      chk("trigger_pulse", int'(bus.O_trigger_pulse), int'(ep));
      chk("index", int'(bus.O_trigger_index), exp_idx(cyc));
      chk("armed", int'(bus.O_armed), int'(m_armed));
      chk("busy", int'(bus.O_busy), int'(m_seq && cyc > m_n && cyc <= m_last));
      chk("done", int'(bus.O_done_pulse), int'(m_seq && cyc == m_last + 1));
`ifdef TRIGGER_MISSED_COUNT_EN
      chk("missed", int'(bus.O_missed_count), missed);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int n, input int d0, input int d1, input int d2, input int d3,
                         input int w0, input int w1, input int w2, input int w3);
    bus.I_num_triggers = (IW+1)'(n);
    bus.I_trigger_delay[0*DW +: DW] = DW'(d0);
    bus.I_trigger_delay[1*DW +: DW] = DW'(d1);
    bus.I_trigger_delay[2*DW +: DW] = DW'(d2);
    bus.I_trigger_delay[3*DW +: DW] = DW'(d3);
    bus.I_trigger_width[0*WW +: WW] = WW'(w0);
    bus.I_trigger_width[1*WW +: WW] = WW'(w1);
    bus.I_trigger_width[2*WW +: WW] = WW'(w2);
    bus.I_trigger_width[3*WW +: WW] = WW'(w3);
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 7),
            $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
  endtask

  task automatic arm();
    bus.I_arm = 1'b1;
    tick();
    bus.I_arm = 1'b0;
  endtask

  task automatic match();
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
  endtask

  logic [16:0] tr, pl, dn;
  int          ix[17];
  int          cnt_t, cnt_d;
  bit          found;

  initial begin
    bus.I_arm   = 1'b0;
    bus.I_abort = 1'b0;
    bus.I_match = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    #1;
    chk("rst_trigger", int'(bus.O_trigger), 0);
    chk("rst_index", int'(bus.O_trigger_index), 0);
    chk("rst_armed", int'(bus.O_armed), 0);
    rst_n = 1'b1;
    tick();

    // Single pulse, zero delay, width 1; an IDLE match first must be ignored.
    set_cfg(1, 0, 9, 9, 9, 1, 9, 9, 9);
    match();
    arm();
    chk("t1_armed", int'(bus.O_armed), 1);
    set_cfg(4, 7, 7, 7, 7, 7, 7, 7, 7);
    repeat (2) tick();
    match();
    chk("t1_trig_hi", int'(bus.O_trigger), 1);
    chk("t1_pulse", int'(bus.O_trigger_pulse), 1);
    chk("t1_armed_fall", int'(bus.O_armed), 0);
    tick();
    chk("t1_trig_lo", int'(bus.O_trigger), 0);
    chk("t1_done", int'(bus.O_done_pulse), 1);
    chk("t1_busy_lo", int'(bus.O_busy), 0);

    // Three pulses, delays {5,0,2}, widths {3,2,0}; config scrambled after arm.
    tick();
    set_cfg(3, 5, 0, 2, 0, 3, 2, 0, 0);
    arm();
    set_cfg(4, 1, 1, 1, 1, 9, 9, 9, 9);
    tick();
    match();
    for (int k = 1; k <= 16; k++) begin
      tr[k] = bus.O_trigger;
      pl[k] = bus.O_trigger_pulse;
      dn[k] = bus.O_done_pulse;
      ix[k] = int'(bus.O_trigger_index);
      bus.I_match = (k == 3 || k == 7);
      tick();
    end
    bus.I_match = 1'b0;
    chk("t2_trig_map", int'(tr), 32'h04DC0);
    chk("t2_pulse_map", int'(pl), 32'h04440);
    chk("t2_done_map", int'(dn), 32'h08000);
    chk("t2_idx_p0", ix[7], 0);
    chk("t2_idx_p1", ix[10], 1);
    chk("t2_idx_p2", ix[14], 2);
    chk("t2_idx_hold", ix[16], 2);

    // Abort during pulse 1; later match without re-arm must do nothing.
    set_cfg(3, 5, 0, 2, 0, 3, 2, 0, 0);
    arm();
    match();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.O_trigger && bus.O_trigger_index == IW'(1)) found = 1'b1;
      else tick();
    end
    chk("t3_reach_p1", int'(found), 1);
    bus.I_abort = 1'b1;
    tick();
    bus.I_abort = 1'b0;
    chk("t3_trig_lo", int'(bus.O_trigger), 0);
    chk("t3_busy_lo", int'(bus.O_busy), 0);
    cnt_t = 0;
    cnt_d = 0;
    for (int k = 0; k < 20; k++) begin
      bus.I_match = (k == 4);
      if (bus.O_trigger) cnt_t++;
      if (bus.O_done_pulse) cnt_d++;
      tick();
    end
    bus.I_match = 1'b0;
    chk("t3_no_done", cnt_d, 0);
    chk("t3_no_trig", cnt_t, 0);

`ifdef TRIGGER_MISSED_COUNT_EN
    set_cfg(1, 400, 0, 0, 0, 1, 0, 0, 0);
    arm();
    match();
    bus.I_match = 1'b1;
    repeat (300) tick();
    bus.I_match = 1'b0;
    chk("missed_sat", int'(bus.O_missed_count), 255);
    bus.I_abort = 1'b1;
    tick();
    bus.I_abort = 1'b0;
`endif

    // Random traffic with config inputs changing every cycle.
    for (int k = 0; k < 4000; k++) begin
      rand_cfg();
      bus.I_arm   = ($urandom_range(0, 7) == 0);
      bus.I_match = ($urandom_range(0, 5) == 0);
      bus.I_abort = ($urandom_range(0, 99) == 0);
      tick();
    end
    bus.I_arm   = 1'b0;
    bus.I_match = 1'b0;
    bus.I_abort = 1'b1;
    tick();
    bus.I_abort = 1'b0;

    // Asynchronous reset in the middle of a pulse.
    set_cfg(1, 2, 0, 0, 0, 6, 0, 0, 0);
    arm();
    match();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.O_trigger) found = 1'b1;
      else tick();
    end
    chk("rs_reach_pulse", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_trig", int'(bus.O_trigger), 0);
    chk("rs_busy", int'(bus.O_busy), 0);
    chk("rs_pulse", int'(bus.O_trigger_pulse), 0);
    chk("rs_index", int'(bus.O_trigger_index), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt_t = 0;
    bus.I_match = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.O_trigger) cnt_t++;
    end
    bus.I_match = 1'b0;
    chk("rs_no_trig", cnt_t, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pw_trigger_seq.md
# pw_trigger_seq

Multi-pulse trigger sequencer for the PhyWhisperer trigger path. After a single pattern-match event it emits a programmable train of up to pNUM_TRIGGERS output pulses, each with its own delay and width. It sits in the trigger_clk domain between the match CDC and the trigger output pins. It replaces the single delay/width trigger with an explicit arm/abort handshake.

## Interface
- pNUM_TRIGGERS, 4: maximum pulses per sequence (≥1)
- pTRIGGER_DELAY_WIDTH, 20: bits per delay field
- pTRIGGER_WIDTH_WIDTH, 17: bits per width field
- pIDX_WIDTH, $clog2(pNUM_TRIGGERS) min 1: pulse index width

- trigger_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- I_arm  in  1  single-cycle arm request; snapshots configuration
- I_abort  in  1  single-cycle abort; returns to IDLE
- I_match  in  1  single-cycle match pulse, already synchronous to trigger_clk
- I_num_triggers  in  pIDX_WIDTH+1  pulses per sequence; 0 treated as 1, values >pNUM_TRIGGERS clamp to pNUM_TRIGGERS
- I_trigger_delay  in  pNUM_TRIGGERS*pTRIGGER_DELAY_WIDTH  packed delays, entry i at [i*W +: W]
- I_trigger_width  in  pNUM_TRIGGERS*pTRIGGER_WIDTH_WIDTH  packed widths, same packing
- O_trigger  out  1  trigger output, registered
- O_trigger_pulse  out  1  high on the first cycle of each O_trigger pulse
- O_trigger_index  out  pIDX_WIDTH  index of current/last pulse
- O_armed  out  1  high in ARMED
- O_busy  out  1  high in DELAY or PULSE
- O_done_pulse  out  1  one cycle after the last pulse completes

## Operation
- States: IDLE, ARMED, DELAY, PULSE. Reset state is IDLE. On reset all outputs are 0 and all counters are 0.
- IDLE: I_arm → ARMED. Delays, widths and count are copied into internal registers. The inputs may then change freely.
- ARMED: I_match → DELAY with index 0.
- DELAY (pulse i): count up to effective delay Di, then → PULSE.
  - D0 = delay[0]. D0 = 0 is legal.
  - Di for i>0 is max(delay[i],1), so a low gap always separates pulses.
- PULSE (pulse i): O_trigger high for Wi = max(width[i],1) cycles.
  - If i+1 < count: → DELAY with i+1.
  - Otherwise: → IDLE with O_done_pulse. The block is not re-armed automatically.
- I_match in IDLE, DELAY or PULSE is ignored.
- I_abort in any state → IDLE next edge. O_trigger is 0 from that edge and no done pulse is issued. Abort wins over a simultaneous I_arm or I_match.
- I_arm outside IDLE is ignored.
- Counters are sized to their fields. A delay of 2^20−1 runs to completion without wrapping.
- O_trigger_index resets to 0, holds the current pulse index, and is cleared to 0 on arm.

## Timing
- Match high in cycle n: pulse 0 is high in cycles n+1+D0 through n+D0+W0 inclusive.
- Pulse i last high in cycle L: pulse i+1 is high in cycles L+1+Di+1 through L+Di+1+Wi+1.
- O_trigger_pulse is high exactly in each pulse's first high cycle.
- O_done_pulse is high in the cycle after the final pulse's last high cycle. O_busy is low in that same cycle.
- O_armed rises the cycle after I_arm and falls the cycle after the accepted I_match.
- Asserting reset_n low mid-sequence clears O_trigger asynchronously. After release the block stays in IDLE until armed.

## Configuration
- TRIGGER_MISSED_COUNT_EN defined:
  - Adds output O_missed_count [7:0], reset 0.
  - Increments, saturating at 255, on every I_match seen in DELAY or PULSE.
  - Cleared on accepted I_arm.
- Macro undefined: port and logic are absent. Ignored matches leave no trace.

## Structure
- pw_trigger_pkg holds:
  - the state enum: IDLE=0, ARMED=1, DELAY=2, PULSE=3
  - the missed-counter width constant (8)
- Sub-module pw_sat_counter is a parametrised saturating counter with clear. It is instantiated only under TRIGGER_MISSED_COUNT_EN.
- Delay and width counters are inline. Field selection uses an indexed part-select on the snapshot registers.

## Test plan
- count=1, delay[0]=0, width[0]=1, match at cycle 10 → O_trigger high only in cycle 11, pulse in 11, done in 12.
- count=3, delays {5,0,2}, widths {3,2,0}, match at cycle 0:
  - O_trigger high in cycles 6–8, 10–11 and 14.
  - Delay 0 is treated as 1 and width 0 as 1.
  - Indices 0, 1, 2; done in cycle 15.
- Arm, then match, then I_abort during pulse 1 → O_trigger low next edge, IDLE, no done pulse. A following match is ignored until re-armed.
- Config inputs changed after arm → generated pulse train still matches the snapshotted values.
- Matches in IDLE and during DELAY → ignored. With TRIGGER_MISSED_COUNT_EN, 300 matches while busy give O_missed_count=255.
- reset_n asserted mid-PULSE → O_trigger 0 immediately, all outputs 0. After release, I_match without I_arm produces no pulse.
